// File: rtl/umi_iso_ctrl.sv
// Isolation sequencer for one UMI request stream feeding umi_isolate.
// Drains in-flight packets before isolating and waits a settle count after pwrgood before releasing.
module umi_iso_ctrl #(
    parameter int unsigned CW         = 32,
    parameter int unsigned AW         = 64,
    parameter int unsigned DW         = 256,
    parameter int unsigned EOMBIT     = 22,
    parameter int unsigned WAKECYCLES = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pwr_req,
    input  logic          pwrgood,
    output logic          pwr_ack,
    output logic          isolate,
    input  logic          in_valid,
    input  logic [CW-1:0] in_cmd,
    input  logic [AW-1:0] in_dstaddr,
    input  logic [AW-1:0] in_srcaddr,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [CW-1:0] out_cmd,
    output logic [AW-1:0] out_dstaddr,
    output logic [AW-1:0] out_srcaddr,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    localparam int unsigned CNTW = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ISO   = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;
    logic            mid_pkt;
    logic            pass;
    logic            hs;

    // State register; isolate/pwr_ack are registered from the next state so they move with it
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_ISO;
            cnt     <= '0;
            isolate <= 1'b1;
            pwr_ack <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            isolate <= (state_nxt == ST_ISO) || (state_nxt == ST_WAKE);
            pwr_ack <= (state_nxt == ST_ISO);
        end
    end

    // Tracks whether the last accepted beat left a packet open
    always_ff @(posedge clk) begin
        if (reset) begin
            mid_pkt <= 1'b0;
        end else if (hs) begin
            mid_pkt <= ~in_cmd[EOMBIT];
        end
    end

    // Next-state and settle counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (pwr_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pwr_req) begin
                    state_nxt = ST_RUN;
                end else if (!mid_pkt) begin
                    state_nxt = ST_ISO;
                end
            end
            ST_ISO: begin
                if (!pwr_req && pwrgood) begin
                    state_nxt = ST_WAKE;
                    cnt_nxt   = CNTW'(WAKECYCLES - 1);
                end
            end
            ST_WAKE: begin
                if (pwr_req || !pwrgood) begin
                    state_nxt = ST_ISO;
                end else if (cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - CNTW'(1);
                end
            end
            default: begin
                state_nxt = ST_ISO;
            end
        endcase
    end

    // Stream gate; payload is a straight wire-through
    always_comb begin
        pass        = (state == ST_RUN) || ((state == ST_DRAIN) && mid_pkt);
        out_valid   = in_valid & pass;
        in_ready    = out_ready & pass;
        hs          = out_valid & out_ready;
        out_cmd     = in_cmd;
        out_dstaddr = in_dstaddr;
        out_srcaddr = in_srcaddr;
        out_data    = in_data;
    end

    // A zero settle count would wrap the 8-bit counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (WAKECYCLES != 0 && WAKECYCLES <= 255)
            else $error("umi_iso_ctrl: WAKECYCLES must be in 1..255");
        end
    end

endmodule
